// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit with HI/LO registers, decoded from the SPECIAL funct field.
// Define MULDIV_FAST_MUL_EN to compute MULT/MULTU with a single-cycle combinational multiplier.
module muldiv_unit #(
   parameter int WIDTH = 32,
   parameter int CNT_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [5:0]       funct,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             flush,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      SIGN = 2'd2
   } state_t;

   state_t state, next_state;

   logic [CNT_W-1:0]   cnt;
   logic               op_mul;
   logic               neg_q;
   logic               neg_r;
   logic [WIDTH-1:0]   mag_a;
   logic [WIDTH-1:0]   mag_b;
   logic [2*WIDTH-1:0] acc;
   logic [WIDTH:0]     rem;
   logic [WIDTH-1:0]   quo;

   logic               is_mul, is_div, is_signed, div_zero_in;
   logic               accept, idle_write;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum;
   logic [WIDTH+1:0]   div_shift, div_diff;
   logic [2*WIDTH-1:0] product, mul_result;

   assign is_mul      = (funct == F_MULT) || (funct == F_MULTU);
   assign is_div      = (funct == F_DIV)  || (funct == F_DIVU);
   assign is_signed   = (funct == F_MULT) || (funct == F_DIV);
   assign div_zero_in = is_div && (op_b == '0);
   assign idle_write  = (state == IDLE) && start && !flush;
   assign accept      = idle_write && (is_mul || is_div);
   assign busy        = (state != IDLE);

   // A zero divisor keeps the raw dividend so the restoring loop naturally
   // leaves quotient = all ones and remainder = op_a with no sign fix.
   always_comb begin
      a_mag = op_a;
      b_mag = op_b;
      if (is_signed && op_a[WIDTH-1] && !div_zero_in)
         a_mag = -op_a;
      if (is_signed && op_b[WIDTH-1])
         b_mag = -op_b;
   end

   // One radix-2 step of shift-add multiply and restoring divide.
   always_comb begin
      mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : {(WIDTH+1){1'b0}});
      div_shift = {rem, quo[WIDTH-1]};
      div_diff  = div_shift - {2'b00, mag_b};
   end

`ifdef MULDIV_FAST_MUL_EN
   assign product = {{WIDTH{1'b0}}, mag_a} * {{WIDTH{1'b0}}, mag_b};
`else
   assign product = acc;
`endif

   assign mul_result = neg_q ? -product : product;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state <= IDLE;
      else
         state <= next_state;
   end

   // Next-state logic; flush overrides everything, including a new start.
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (accept) begin
`ifdef MULDIV_FAST_MUL_EN
               next_state = is_mul ? SIGN : CALC;
`else
               next_state = CALC;
`endif
            end
         end
         CALC: begin
            if (cnt == '0)
               next_state = SIGN;
         end
         SIGN:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
      if (flush)
         next_state = IDLE;
   end

   // Datapath and architectural HI/LO; HI/LO only change on MTHI/MTLO or a completed op.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         op_mul <= 1'b0;
         neg_q  <= 1'b0;
         neg_r  <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         rem    <= '0;
         quo    <= '0;
         hi     <= '0;
         lo     <= '0;
         done   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (accept) begin
            cnt    <= CNT_W'(WIDTH - 1);
            op_mul <= is_mul;
            neg_q  <= is_signed && !div_zero_in && (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
            neg_r  <= is_signed && is_div && !div_zero_in && op_a[WIDTH-1];
            mag_a  <= a_mag;
            mag_b  <= b_mag;
            acc    <= {{WIDTH{1'b0}}, b_mag};
            rem    <= '0;
            quo    <= a_mag;
         end else if (idle_write && (funct == F_MTHI)) begin
            hi <= op_a;
         end else if (idle_write && (funct == F_MTLO)) begin
            lo <= op_a;
         end else if ((state == CALC) && !flush) begin
            cnt <= cnt - CNT_W'(1);
            if (op_mul) begin
               acc <= {mul_sum, acc[WIDTH-1:1]};
            end else begin
               rem <= div_diff[WIDTH+1] ? div_shift[WIDTH:0] : div_diff[WIDTH:0];
               quo <= {quo[WIDTH-2:0], ~div_diff[WIDTH+1]};
            end
         end else if ((state == SIGN) && !flush) begin
            done <= 1'b1;
            if (op_mul) begin
               hi <= mul_result[2*WIDTH-1:WIDTH];
               lo <= mul_result[WIDTH-1:0];
            end else begin
               lo <= neg_q ? -quo : quo;
               hi <= neg_r ? -rem[WIDTH-1:0] : rem[WIDTH-1:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: cycle-level arithmetic model plus directed literal checks.
module tb_muldiv_unit;

   localparam logic [5:0] F_MULT  = 6'b011000;
   localparam logic [5:0] F_MULTU = 6'b011001;
   localparam logic [5:0] F_DIV   = 6'b011010;
   localparam logic [5:0] F_DIVU  = 6'b011011;
   localparam logic [5:0] F_MTHI  = 6'b010001;
   localparam logic [5:0] F_MTLO  = 6'b010011;

   logic        clk, rst_n, start, flush;
   logic [5:0]  funct;
   logic [31:0] op_a, op_b;
   logic        busy, done;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;

   muldiv_unit #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .funct (funct),
      .op_a  (op_a),
      .op_b  (op_b),
      .flush (flush),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
      end
   endtask

   function automatic bit is_muldiv(input logic [5:0] f);
      return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
   endfunction

   function automatic int op_latency(input logic [5:0] f);
`ifdef MULDIV_FAST_MUL_EN
      if ((f == F_MULT) || (f == F_MULTU))
         return 1;
`endif
      return 33;
   endfunction

   // Architectural result {hi, lo} straight from the arithmetic definition.
   function automatic logic [63:0] model_result(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      longint sa, sb;
      logic [63:0] p;
      logic [31:0] q, r;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p = '0;
      case (f)
         F_MULT:  p = 64'(sa * sb);
         F_MULTU: p = {32'b0, a} * {32'b0, b};
         F_DIV: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else begin
               q = 32'(sa / sb);
               r = 32'(sa % sb);
               p = {r, q};
            end
         end
         F_DIVU: begin
            if (b == 0) p = {a, 32'hFFFF_FFFF};
            else p = {a % b, a / b};
         end
         default: p = '0;
      endcase
      return p;
   endfunction

   // Behavioural model: remaining busy cycles plus the pending result.
   int          m_left;
   logic        m_done;
   logic [31:0] m_hi, m_lo;
   logic [63:0] m_pend;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_left <= 0;
         m_done <= 1'b0;
         m_hi   <= '0;
         m_lo   <= '0;
         m_pend <= '0;
      end else begin
         m_done <= 1'b0;
         if (flush) begin
            m_left <= 0;
         end else if (m_left != 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
               m_hi   <= m_pend[63:32];
               m_lo   <= m_pend[31:0];
               m_done <= 1'b1;
            end
         end else if (start) begin
            if (is_muldiv(funct)) begin
               m_pend <= model_result(funct, op_a, op_b);
               m_left <= op_latency(funct);
            end else if (funct == F_MTHI) begin
               m_hi <= op_a;
            end else if (funct == F_MTLO) begin
               m_lo <= op_a;
            end
         end
      end
   end

   // Compare every cycle the unit is out of reset.
   always @(negedge clk) begin
      if (rst_n === 1'b1) begin
         check_output("busy", {31'b0, busy}, {31'b0, (m_left != 0)});
         check_output("done", {31'b0, done}, {31'b0, m_done});
         check_output("hi", hi, m_hi);
         check_output("lo", lo, m_lo);
      end
   end

   // Issue one op and wait (bounded) for done; leaves the bench at the negedge where done is high.
   task automatic apply_stimulus(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                 input bit same_cycle, output int busy_cycles, output int done_cycle);
      if (!same_cycle) @(negedge clk);
      start = 1'b1;
      funct = f;
      op_a  = a;
      op_b  = b;
      @(negedge clk);
      start = 1'b0;
      op_a  = $urandom;
      op_b  = $urandom;
      busy_cycles = 0;
      done_cycle  = -1;
      for (int c = 0; c < 100 && done_cycle < 0; c++) begin
         if (busy) busy_cycles++;
         if (done) done_cycle = c;
         if (done_cycle < 0) @(negedge clk);
      end
      if (done_cycle < 0)
         check_output("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic write_mt(input logic [5:0] f, input logic [31:0] v);
      @(negedge clk);
      start = 1'b1;
      funct = f;
      op_a  = v;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic start_only(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      start = 1'b1;
      funct = f;
      op_a  = a;
      op_b  = b;
      @(negedge clk);
      start = 1'b0;
   endtask

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 7))
         0: return 32'h0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h1;
         4: return $urandom_range(0, 255);
         default: return $urandom;
      endcase
   endfunction

   initial begin
      int bc, dc, lat_mul;
      logic [5:0] fl [6];
      fl[0] = F_MULT; fl[1] = F_MULTU; fl[2] = F_DIV;
      fl[3] = F_DIVU; fl[4] = F_MTHI;  fl[5] = F_MTLO;
      lat_mul = op_latency(F_MULT);

      rst_n = 1'b1; start = 1'b0; flush = 1'b0; funct = '0; op_a = '0; op_b = '0;
      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check_output("reset_busy", {31'b0, busy}, 32'd0);
      check_output("reset_hi", hi, 32'h0);
      check_output("reset_lo", lo, 32'h0);
      rst_n = 1'b1;

      $display("[TB] directed arithmetic");
      apply_stimulus(F_MULT, 32'hFFFF_FFFF, 32'd5, 1'b0, bc, dc);
      check_output("mult_hi", hi, 32'hFFFF_FFFF);
      check_output("mult_lo", lo, 32'hFFFF_FFFB);
      check_output("mult_busy_cycles", bc, lat_mul);
      check_output("mult_done_cycle", dc, lat_mul);

      apply_stimulus(F_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, bc, dc);
      check_output("multu_hi", hi, 32'hFFFF_FFFE);
      check_output("multu_lo", lo, 32'h0000_0001);

      apply_stimulus(F_DIV, 32'hFFFF_FFF9, 32'h2, 1'b0, bc, dc);
      check_output("div_neg_lo", lo, 32'hFFFF_FFFD);
      check_output("div_neg_hi", hi, 32'hFFFF_FFFF);
      check_output("div_busy_cycles", bc, 33);
      check_output("div_done_cycle", dc, 33);

      apply_stimulus(F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc, dc);
      check_output("div_ovf_lo", lo, 32'h8000_0000);
      check_output("div_ovf_hi", hi, 32'h0);

      apply_stimulus(F_DIVU, 32'h64, 32'h0, 1'b0, bc, dc);
      check_output("divu_zero_lo", lo, 32'hFFFF_FFFF);
      check_output("divu_zero_hi", hi, 32'h64);

      // Back-to-back: next op issued in the very cycle done is high.
      apply_stimulus(F_MULTU, 32'd3, 32'd4, 1'b1, bc, dc);
      check_output("b2b_lo", lo, 32'd12);
      check_output("b2b_hi", hi, 32'd0);

      $display("[TB] MTHI/MTLO");
      write_mt(F_MTHI, 32'h1234);
      check_output("mthi_hi", hi, 32'h1234);
      check_output("mthi_done", {31'b0, done}, 32'd0);

      start_only(F_DIVU, 32'd100, 32'd7);
      repeat (3) @(negedge clk);
      start = 1'b1; funct = F_MTLO; op_a = 32'hDEAD;
      @(negedge clk);
      start = 1'b0;
      dc = -1;
      for (int c = 0; c < 100 && dc < 0; c++) begin
         if (done) dc = c;
         else @(negedge clk);
      end
      if (dc < 0) check_output("mtlo_busy_timeout", 32'd0, 32'd1);
      check_output("mtlo_busy_lo", lo, 32'd14);
      check_output("mtlo_busy_hi", hi, 32'd2);

      $display("[TB] flush abort");
      write_mt(F_MTHI, 32'hAA);
      write_mt(F_MTLO, 32'hBB);
      start_only(F_DIVU, 32'd1000, 32'd3);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      check_output("flush_busy", {31'b0, busy}, 32'd0);
      check_output("flush_hi", hi, 32'hAA);
      check_output("flush_lo", lo, 32'hBB);
      repeat (40) @(negedge clk);
      check_output("flush_hi_later", hi, 32'hAA);

      $display("[TB] reset mid-operation");
      start_only(F_DIVU, 32'd1000, 32'd3);
      repeat (5) @(negedge clk);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check_output("rst_mid_busy", {31'b0, busy}, 32'd0);
      check_output("rst_mid_hi", hi, 32'h0);
      check_output("rst_mid_lo", lo, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] random traffic");
      for (int i = 0; i < 3000; i++) begin
         @(negedge clk);
         start = ($urandom_range(0, 3) == 0);
         funct = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, 5)];
         op_a  = rand_operand();
         op_b  = rand_operand();
         flush = ($urandom_range(0, 80) == 0);
      end
      @(negedge clk);
      start = 1'b0;
      flush = 1'b0;
      repeat (40) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
